// File: rtl/sqrt_converge_monitor_if.sv
// sqrt_converge_monitor_if: operand/estimate inputs and held-result handshake of the sqrt monitor
interface sqrt_converge_monitor_if #(parameter int IW = 8);
  logic start_i;
  logic [31:0] a_i;
  logic [31:0] est_i;
  logic est_valid_i;
  logic result_ready_i;
  logic [31:0] result_o;
  logic result_valid_o;
  logic busy_o;
  logic converged_o;
  logic [IW-1:0] iter_count_o;
  modport master (
    output start_i, a_i, est_i, est_valid_i, result_ready_i,
    input result_o, result_valid_o, busy_o, converged_o, iter_count_o
  );
  modport slave (
    input start_i, a_i, est_i, est_valid_i, result_ready_i,
    output result_o, result_valid_o, busy_o, converged_o, iter_count_o
  );
endinterface

// File: rtl/sqrt_converge_monitor.sv
// sqrt_converge_monitor: resolves IEEE-754 sqrt specials, watches NR estimates for convergence/timeout.
// Optional SQRT_MON_STATS_EN adds ops_done_o/timeouts_o handshake counters.
module sqrt_converge_monitor #(
  parameter int MAX_ITER = 16,
  parameter int TOL_ULP = 1,
  parameter int IW = 8
) (
  input logic sqrt_clk,
  input logic rst_n,
`ifdef SQRT_MON_STATS_EN
  output logic [15:0] ops_done_o,
  output logic [15:0] timeouts_o,
`endif
  sqrt_converge_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SPECIAL, ITER, HOLD} state_t;
  state_t state_q;
  logic [31:0] a_q, result_q;
  logic [30:0] prev_q;
  logic rv_q, busy_q, conv_q;
  logic [IW-1:0] cnt_q;
  logic [IW-1:0] cnt_d;
  logic [30:0] diff;
  logic a_special, est_bad, close, tmo;
  logic [31:0] special_res;
  assign a_special = bus.a_i[30:0] == '0 || bus.a_i[31] || &bus.a_i[30:23];
  // NaN keeps its payload (quieted) even when negative
  assign special_res = a_q[30:0] == '0 ? a_q :
                       (&a_q[30:23] && |a_q[22:0]) ? a_q | 32'h0040_0000 :
                       a_q[31] ? 32'h7FC0_0000 : 32'h7F80_0000;
  assign cnt_d = &cnt_q ? cnt_q : cnt_q + IW'(1);
  assign diff = bus.est_i[30:0] >= prev_q ? bus.est_i[30:0] - prev_q : prev_q - bus.est_i[30:0];
  assign est_bad = bus.est_i[31] || (&bus.est_i[30:23] && |bus.est_i[22:0]);
  assign close = cnt_q != '0 && diff <= 31'(TOL_ULP);
  assign tmo = int'(cnt_d) >= MAX_ITER;
  always_ff @(posedge sqrt_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      prev_q <= '0;
      result_q <= '0;
      rv_q <= 1'b0;
      busy_q <= 1'b0;
      conv_q <= 1'b0;
      cnt_q <= '0;
    end else
      case (state_q)
        IDLE:
          if (bus.start_i) begin
            a_q <= bus.a_i;
            cnt_q <= '0;
            busy_q <= 1'b1;
            state_q <= a_special ? SPECIAL : ITER;
          end
        SPECIAL: begin
          result_q <= special_res;
          conv_q <= 1'b1;
          busy_q <= 1'b0;
          rv_q <= 1'b1;
          state_q <= HOLD;
        end
        ITER:
          if (bus.est_valid_i) begin
            cnt_q <= cnt_d;
            prev_q <= bus.est_i[30:0];
            if (est_bad || close || tmo) begin
              result_q <= est_bad ? 32'h7FC0_0000 : bus.est_i;
              conv_q <= !est_bad && close;
              busy_q <= 1'b0;
              rv_q <= 1'b1;
              state_q <= HOLD;
            end
          end
        HOLD:
          if (bus.result_ready_i) begin
            rv_q <= 1'b0;
            state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
  assign bus.result_o = result_q;
  assign bus.result_valid_o = rv_q;
  assign bus.busy_o = busy_q;
  assign bus.converged_o = conv_q;
  assign bus.iter_count_o = cnt_q;
`ifdef SQRT_MON_STATS_EN
  logic [15:0] ops_q, tmo_q;
  always_ff @(posedge sqrt_clk or negedge rst_n)
    if (!rst_n) begin
      ops_q <= '0;
      tmo_q <= '0;
    end else if (state_q == HOLD && bus.result_ready_i) begin
      ops_q <= ops_q + 16'd1;
      tmo_q <= tmo_q + {15'd0, !conv_q};
    end
  assign ops_done_o = ops_q;
  assign timeouts_o = tmo_q;
`endif
endmodule

// File: tb/tb_sqrt_converge_monitor.sv
// tb_sqrt_converge_monitor: vector table + scoreboard bench; u0 uses MAX_ITER=16, u1 uses MAX_ITER=4.
module tb_sqrt_converge_monitor;
  typedef struct { bit sel; logic [31:0] a; int n; logic [31:0] res; bit conv; int cnt; } vec_t;
  typedef struct { logic [31:0] res; bit conv; int cnt; int lat; } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit sel = 1'b0;
  logic start = 1'b0, ev = 1'b0, rdy = 1'b0;
  logic [31:0] a = '0, est = '0;
  int checks = 0, failures = 0;
  int eix = 0;
  int exp_ops [2] = '{0, 0};
  int exp_tmo [2] = '{0, 0};
  vec_t vt[$];
  exp_t sbq[$];
  logic [31:0] et [22] = '{
    32'h3F800000, 32'h40200000, 32'h40033333, 32'h40000000, 32'h40000000,
    32'h3F800000, 32'h3FC00000, 32'h3FB00000, 32'h3FB60000,
    32'h3F800000, 32'h3F800001,
    32'h3F800000, 32'h3F800002, 32'h3F800003,
    32'h3F800000, 32'hBF800000,
    32'h3F000000, 32'h3F100000, 32'h3F200000, 32'h3F200001,
    32'h3F800000, 32'h7FC00000
  };
  always #5 clk = ~clk;
  sqrt_converge_monitor_if if0 ();
  sqrt_converge_monitor_if if1 ();
  assign if0.start_i = start & !sel;
  assign if1.start_i = start & sel;
  assign if0.result_ready_i = rdy & !sel;
  assign if1.result_ready_i = rdy & sel;
  assign if0.a_i = a;
  assign if1.a_i = a;
  assign if0.est_i = est;
  assign if1.est_i = est;
  assign if0.est_valid_i = ev;
  assign if1.est_valid_i = ev;
`ifdef SQRT_MON_STATS_EN
  logic [15:0] ops0, tmo0, ops1, tmo1;
`endif
  sqrt_converge_monitor u0 (
    .sqrt_clk(clk),
    .rst_n(rst_n),
`ifdef SQRT_MON_STATS_EN
    .ops_done_o(ops0),
    .timeouts_o(tmo0),
`endif
    .bus(if0)
  );
  sqrt_converge_monitor #(.MAX_ITER(4)) u1 (
    .sqrt_clk(clk),
    .rst_n(rst_n),
`ifdef SQRT_MON_STATS_EN
    .ops_done_o(ops1),
    .timeouts_o(tmo1),
`endif
    .bus(if1)
  );
  logic [31:0] res_s;
  logic rv_s, busy_s, conv_s;
  logic [7:0] cnt_s;
  assign res_s = sel ? if1.result_o : if0.result_o;
  assign rv_s = sel ? if1.result_valid_o : if0.result_valid_o;
  assign busy_s = sel ? if1.busy_o : if0.busy_o;
  assign conv_s = sel ? if1.converged_o : if0.converged_o;
  assign cnt_s = sel ? if1.iter_count_o : if0.iter_count_o;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  task automatic add(bit s, logic [31:0] av, int n, logic [31:0] res, bit c, int cnt);
    vec_t v;
    v.sel = s;
    v.a = av;
    v.n = n;
    v.res = res;
    v.conv = c;
    v.cnt = cnt;
    vt.push_back(v);
  endtask
  task automatic run(input vec_t v);
    exp_t e;
    int lat = 1;
    int k = 0;
    sel = v.sel;
    e.res = v.res;
    e.conv = v.conv;
    e.cnt = v.cnt;
    e.lat = v.n == 0 ? 2 : v.n + 1;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b1;
    a = v.a;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start", {31'd0, busy_s}, 1);
    while (!rv_s && lat < 40) begin
      ev = k < v.n;
      est = k < v.n ? et[eix + k] : 32'h0;
      k++;
      @(negedge clk);
      lat++;
    end
    ev = 1'b0;
    eix += v.n;
    e = sbq.pop_front();
    chk("result_valid", {31'd0, rv_s}, 1);
    chk("result", res_s, e.res);
    chk("converged", {31'd0, conv_s}, {31'd0, e.conv});
    chk("iter_count", {24'd0, cnt_s}, e.cnt);
    chk("latency", lat, e.lat);
    chk("busy_hold", {31'd0, busy_s}, 0);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk("valid_drop", {31'd0, rv_s}, 0);
    exp_ops[v.sel]++;
    exp_tmo[v.sel] += v.conv ? 0 : 1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    add(0, 32'h40800000, 5, 32'h40000000, 1, 5);
    add(1, 32'h40000000, 4, 32'h3FB60000, 0, 4);
    add(0, 32'h80000000, 0, 32'h80000000, 1, 0);
    add(0, 32'hC0800000, 0, 32'h7FC00000, 1, 0);
    add(0, 32'h7F800000, 0, 32'h7F800000, 1, 0);
    add(0, 32'h7F800001, 0, 32'h7FC00001, 1, 0);
    add(0, 32'h00000000, 0, 32'h00000000, 1, 0);
    add(0, 32'h3F800000, 2, 32'h3F800001, 1, 2);
    add(0, 32'h3F800000, 3, 32'h3F800003, 1, 3);
    add(0, 32'h40000000, 2, 32'h7FC00000, 0, 2);
    add(1, 32'h40800000, 4, 32'h3F200001, 1, 4);
    add(1, 32'h40000000, 2, 32'h7FC00000, 0, 2);
    add(1, 32'hFF800000, 0, 32'h7FC00000, 1, 0);
    add(0, 32'h7F800000, 0, 32'h7F800000, 1, 0);
    repeat (2) @(negedge clk);
    chk("rst_result", res_s, 0);
    chk("rst_valid", {31'd0, rv_s}, 0);
    chk("rst_busy", {31'd0, busy_s}, 0);
    chk("rst_conv", {31'd0, conv_s}, 0);
    chk("rst_count", {24'd0, cnt_s}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    a = 32'h40800000;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ev = 1'b1;
      est = 32'h3F800000 + i * 32'h00100000;
      @(negedge clk);
    end
    ev = 1'b0;
    chk("mid_count", {24'd0, cnt_s}, 3);
    chk("mid_busy", {31'd0, busy_s}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy_s}, 0);
    chk("async_count", {24'd0, cnt_s}, 0);
    chk("async_valid", {31'd0, rv_s}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) run(vt[i]);
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    ev = 1'b1;
    est = 32'h3F800000;
    @(negedge clk);
    @(negedge clk);
    ev = 1'b0;
    chk("bp_valid", {31'd0, rv_s}, 1);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      a = 32'h7F800000;
      ev = !i[0];
      est = 32'h12345678;
      @(negedge clk);
      chk("bp_hold", {rv_s, busy_s, conv_s, cnt_s, res_s[20:0]}, {1'b1, 1'b0, 1'b1, 8'd2, 21'h000000});
      chk("bp_result", res_s, 32'h3F800000);
    end
    ev = 1'b0;
    rdy = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    start = 1'b0;
    chk("accept_valid", {31'd0, rv_s}, 0);
    chk("accept_busy", {31'd0, busy_s}, 0);
    @(negedge clk);
    chk("accept_idle", {31'd0, busy_s}, 0);
    exp_ops[0]++;
    run(vt[13]);
`ifdef SQRT_MON_STATS_EN
    chk("ops_done0", {16'd0, ops0}, exp_ops[0]);
    chk("timeouts0", {16'd0, tmo0}, exp_tmo[0]);
    chk("ops_done1", {16'd0, ops1}, exp_ops[1]);
    chk("timeouts1", {16'd0, tmo1}, exp_tmo[1]);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
